pipe_skid_latch: RTL and testbench
==================================

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter BUS_DATA, default 8, payload width in bits.
REQ-002 Parameter STALL_W, default 16, width of the stall-cycle counter.
REQ-003 i_clock  input  1  clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_flush  input  1  synchronous discard of all held entries.
REQ-006 i_data  input  BUS_DATA  upstream payload.
REQ-007 i_valid  input  1  upstream payload valid.
REQ-008 o_ready  output  1  stage can accept a payload this cycle.
REQ-009 o_data  output  BUS_DATA  downstream payload (head entry).
REQ-010 o_valid  output  1  o_data valid.
REQ-011 i_ready  input  1  downstream accepts o_data this cycle.
REQ-012 o_count  output  2  entries held, 0..2.
REQ-013 o_stall_cycles  output  STALL_W  saturating count of downstream-stalled cycles.

Function
REQ-014 Stage SHALL hold up to two entries: head register (drives o_data) and skid register.
REQ-015 States SHALL be EMPTY (0 entries), ONE (head only), FULL (head+skid); o_count = 0/1/2 respectively.
REQ-016 o_valid SHALL equal (state != EMPTY); o_ready SHALL equal (state != FULL); both decoded from state register only, no combinational path from i_ready or i_valid.
REQ-017 Accept = i_valid & o_ready; take = o_valid & i_ready; payload transfers only on these.
REQ-018 EMPTY: accept -> ONE, head <= i_data; else stay EMPTY.
REQ-019 ONE: accept & take -> ONE, head <= i_data; accept & !take -> FULL, skid <= i_data; !accept & take -> EMPTY; neither -> ONE, head unchanged.
REQ-020 FULL: take -> ONE, head <= skid; !take -> FULL, both registers unchanged; no accept possible.
REQ-021 Latency SHALL be 1 cycle: payload accepted in cycle N appears on o_data with o_valid=1 in cycle N+1 when stage was EMPTY or taken in N.
REQ-022 Ordering SHALL be strict FIFO; no payload dropped or duplicated without flush/reset.
REQ-023 o_data SHALL remain stable while o_valid=1 and i_ready=0.
REQ-024 i_flush=1 SHALL force state EMPTY and head, skid to 0 next cycle; same-cycle accept and take are discarded/ignored.
REQ-025 o_stall_cycles SHALL increment by 1 each cycle o_valid=1 and i_ready=0, saturate at 2^STALL_W-1, be unaffected by i_flush.
REQ-026 With BUS_DATA=1 and any STALL_W>=1 behaviour SHALL be unchanged apart from widths.

Reset
REQ-027 i_reset SHALL take priority over i_flush and all handshakes.
REQ-028 Reset cycle result: state EMPTY, head=0, skid=0, o_data=0, o_valid=0, o_ready=1, o_count=0, o_stall_cycles=0.
REQ-029 Reset asserted mid-transfer SHALL discard held entries and the same-cycle accept.
REQ-030 i_valid in the first cycle after reset deassertion SHALL be accepted (o_ready=1).

Verification
REQ-031 Pass-through: i_ready=1, i_valid=1, data 0x11,0x22,0x33 on consecutive cycles -> o_data 0x11,0x22,0x33 one cycle later, o_count=1, o_ready stays 1.
REQ-032 Skid fill: i_ready=0, send 0xA1 then 0xA2 -> o_count 1 then 2, o_ready=0, o_data=0xA1 stable; 0xA3 offered, not accepted; i_ready=1 -> 0xA1, 0xA2 delivered in order, o_count 2->1->0.
REQ-033 Flush while FULL with i_valid=1 (0x5C) -> next cycle o_valid=0, o_data=0, o_count=0, o_ready=1; 0x5C never appears.
REQ-034 Stall saturation, STALL_W=2: hold o_valid=1, i_ready=0 for 6 cycles -> o_stall_cycles 1,2,3,3,3,3; flush leaves it 3; reset clears to 0.
REQ-035 Reset mid-operation: FULL with 0x0F,0xF0, assert i_reset with i_flush=1, i_valid=1 -> all outputs per REQ-028; first post-reset payload 0x77 appears after 1 cycle.
REQ-036 Random ready/valid, 1000 cycles, scoreboard: output sequence equals accepted input sequence; o_ready never 1 when o_count=2.

Source files
------------

// File: rtl/pipe_skid_latch.sv
// Two-entry valid/ready pipeline stage with a registered skid slot.
// Handshake outputs decode from state only; stalls are counted saturating.
module pipe_skid_latch #(
    parameter int BUS_DATA = 8,
    parameter int STALL_W  = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_flush,
    input  logic [BUS_DATA-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [BUS_DATA-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [1:0]          o_count,
    output logic [STALL_W-1:0]  o_stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_DATA-1:0] head_q, head_d;
    logic [BUS_DATA-1:0] skid_q, skid_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                accept, take;

    assign o_valid        = (state_q != EMPTY);
    assign o_ready        = (state_q != FULL);
    assign o_data         = head_q;
    assign o_count        = state_q;
    assign o_stall_cycles = stall_q;

    assign accept = i_valid & o_ready;
    assign take   = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (o_valid && !i_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = i_data;
                end
            end
            ONE: begin
                if (accept && take) begin
                    head_d = i_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = i_data;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush drops entries but leaves the stall statistic alone
        if (i_flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: queue-based reference plus directed
// literal checks and a random handshake run.
module tb_pipe_skid_latch;

    localparam int BW = 8;
    localparam int SW = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_flush = 1'b0;
    logic [BW-1:0] i_data  = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [BW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [1:0]    o_count;
    logic [SW-1:0] o_stall_cycles;

    pipe_skid_latch #(.BUS_DATA(BW), .STALL_W(SW)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_flush        (i_flush),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_count        (o_count),
        .o_stall_cycles (o_stall_cycles)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: FIFO of at most two payloads; the output shows the
    // oldest entry, or the last one delivered once the FIFO drains.
    logic [BW-1:0] mq[$];
    logic [BW-1:0] m_last = '0;
    int            m_stall = 0;

    always @(posedge i_clock) begin
        bit acc, tk;
        if (i_reset) begin
            mq.delete();
            m_last  = '0;
            m_stall = 0;
        end else begin
            if (mq.size() != 0 && !i_ready && m_stall < SMAX)
                m_stall++;
            if (i_flush) begin
                mq.delete();
                m_last = '0;
            end else begin
                acc = i_valid && (mq.size() < 2);
                tk  = (mq.size() > 0) && i_ready;
                if (tk) m_last = mq.pop_front();
                if (acc) mq.push_back(i_data);
            end
        end
    end

    always @(negedge i_clock) begin
        if (started) begin
            chk("model o_valid", 32'(o_valid), 32'(mq.size() != 0));
            chk("model o_ready", 32'(o_ready), 32'(mq.size() < 2));
            chk("model o_count", 32'(o_count), 32'(mq.size()));
            chk("model o_data", 32'(o_data),
                32'((mq.size() != 0) ? mq[0] : m_last));
            chk("model stall", 32'(o_stall_cycles), 32'(m_stall));
            if (o_count == 2'd2)
                chk("ready when full", 32'(o_ready), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " o_valid"}, 32'(o_valid), 32'd0);
        chk({tag, " o_ready"}, 32'(o_ready), 32'd1);
        chk({tag, " o_count"}, 32'(o_count), 32'd0);
        chk({tag, " o_data"}, 32'(o_data), 32'd0);
        chk({tag, " stall"}, 32'(o_stall_cycles), 32'd0);
    endtask

    logic [BW-1:0] pt_data [3] = '{8'h11, 8'h22, 8'h33};
    int            sat_exp [5] = '{2, 3, 3, 3, 3};

    initial begin
        cyc();
        started = 1'b1;
        chk_reset_state("reset");
        i_reset = 1'b0;

        // Pass-through with downstream always ready
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data = pt_data[k];
            cyc();
            chk("pt o_data", 32'(o_data), 32'(pt_data[k]));
            chk("pt o_count", 32'(o_count), 32'd1);
            chk("pt o_ready", 32'(o_ready), 32'd1);
        end
        i_valid = 1'b0;
        cyc();
        chk("pt drain count", 32'(o_count), 32'd0);

        // Skid fill under backpressure
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hA1;
        cyc();
        chk("skid cnt1", 32'(o_count), 32'd1);
        i_data = 8'hA2;
        cyc();
        chk("skid cnt2", 32'(o_count), 32'd2);
        chk("skid rdy0", 32'(o_ready), 32'd0);
        chk("skid head", 32'(o_data), 32'hA1);
        i_data = 8'hA3;
        cyc();
        chk("skid hold", 32'(o_data), 32'hA1);
        chk("skid stall", 32'(o_stall_cycles), 32'd2);
        i_valid = 1'b0;
        i_ready = 1'b1;
        cyc();
        chk("skid out2", 32'(o_data), 32'hA2);
        chk("skid cnt1b", 32'(o_count), 32'd1);
        cyc();
        chk("skid cnt0", 32'(o_count), 32'd0);

        // Stall saturation
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h0F;
        cyc();
        i_data = 8'hF0;
        cyc();
        chk("sat first", 32'(o_stall_cycles), 32'd1);
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("sat seq", 32'(o_stall_cycles), 32'(sat_exp[k]));
        end

        // Flush while full with a competing payload
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h5C;
        cyc();
        chk("flush o_valid", 32'(o_valid), 32'd0);
        chk("flush o_data", 32'(o_data), 32'd0);
        chk("flush o_count", 32'(o_count), 32'd0);
        chk("flush o_ready", 32'(o_ready), 32'd1);
        chk("flush stall", 32'(o_stall_cycles), 32'd3);
        i_flush = 1'b0;
        i_valid = 1'b0;
        cyc();
        chk("no 5C", 32'(o_valid), 32'd0);

        // Reset mid-operation beats flush and accept
        i_valid = 1'b1;
        i_data  = 8'h0F;
        cyc();
        i_data = 8'hF0;
        cyc();
        chk("pre-rst full", 32'(o_count), 32'd2);
        i_reset = 1'b1;
        i_flush = 1'b1;
        i_data  = 8'h5C;
        cyc();
        chk_reset_state("midrst");
        i_reset = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        i_data  = 8'h77;
        cyc();
        chk("post-rst data", 32'(o_data), 32'h77);
        chk("post-rst valid", 32'(o_valid), 32'd1);
        i_valid = 1'b0;
        cyc();

        // Random handshake traffic against the reference
        for (int k = 0; k < 1000; k++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            i_data  = BW'($urandom);
            i_flush = ($urandom_range(0, 63) == 0);
            cyc();
        end
        i_flush = 1'b0;
        i_valid = 1'b0;
        cyc();

        @(negedge i_clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
